// File: rtl/de_hazard_pipe.sv
// D/E pipeline register with a stall scoreboard tracking E/M destination and Tnew.
// Build macro MD_STALL_EN: when defined, HILO ops in D also stall while the mul/div unit is busy.
module de_hazard_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] D_pc,
    input  logic [31:0] D_instr,
    input  logic [31:0] D_rs,
    input  logic [31:0] D_rt,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    input  logic [4:0]  D_A3,
    input  logic [1:0]  D_Tuse_rs,
    input  logic [1:0]  D_Tuse_rt,
    input  logic [1:0]  D_Tnew,
    input  logic [3:0]  D_HILOtype,
    input  logic        HILObusy,
    output logic        stall,
    output logic [31:0] E_pc,
    output logic [31:0] E_instr,
    output logic [31:0] E_rs,
    output logic [31:0] E_rt,
    output logic [4:0]  E_A3,
    output logic [1:0]  E_Tnew,
    output logic [3:0]  E_HILOtype,
    output logic [4:0]  M_A3,
    output logic [1:0]  M_Tnew
);

    // Stall contract: stall is combinational; while high, upstream holds F/D
    // and this block loads a bubble into E. The D instruction advances on the
    // first rising edge where stall is low.
    logic rs_haz;
    logic rt_haz;
    logic md_haz;

    always_comb begin
        rs_haz = 1'b0;
        rt_haz = 1'b0;
        if (D_rs_addr != 5'd0 && D_Tuse_rs != 2'd3) begin
            rs_haz = (E_A3 == D_rs_addr && E_Tnew > D_Tuse_rs) ||
                     (M_A3 == D_rs_addr && M_Tnew > D_Tuse_rs);
        end
        if (D_rt_addr != 5'd0 && D_Tuse_rt != 2'd3) begin
            rt_haz = (E_A3 == D_rt_addr && E_Tnew > D_Tuse_rt) ||
                     (M_A3 == D_rt_addr && M_Tnew > D_Tuse_rt);
        end
    end

`ifdef MD_STALL_EN
    assign md_haz = (D_HILOtype != 4'd0) && HILObusy;
`else
    // Single-cycle mul/div model: busy never matters, the term is tied off.
    assign md_haz = HILObusy & 1'b0;
`endif

    assign stall = rs_haz | rt_haz | md_haz;

    always_ff @(posedge clk) begin
        if (reset) begin
            E_pc       <= 32'd0;
            E_instr    <= 32'd0;
            E_rs       <= 32'd0;
            E_rt       <= 32'd0;
            E_A3       <= 5'd0;
            E_Tnew     <= 2'd0;
            E_HILOtype <= 4'd0;
            M_A3       <= 5'd0;
            M_Tnew     <= 2'd0;
        end else begin
            M_A3   <= E_A3;
            M_Tnew <= (E_Tnew == 2'd0) ? 2'd0 : E_Tnew - 2'd1;
            if (stall) begin
                // Bubble keeps the PC so a later exception can still report it.
                E_pc       <= D_pc;
                E_instr    <= 32'd0;
                E_rs       <= 32'd0;
                E_rt       <= 32'd0;
                E_A3       <= 5'd0;
                E_Tnew     <= 2'd0;
                E_HILOtype <= 4'd0;
            end else begin
                E_pc       <= D_pc;
                E_instr    <= D_instr;
                E_rs       <= D_rs;
                E_rt       <= D_rt;
                E_A3       <= D_A3;
                E_Tnew     <= D_Tnew;
                E_HILOtype <= D_HILOtype;
            end
        end
    end

endmodule
